// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: VGA scanout has fixed priority, the CPU is
// served in free slots and may steal one VGA slot after waiting MAX_WAIT-1 cycles.
module vram_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int MAX_WAIT = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_address,
   output logic [7:0]        vga_data,
   output logic              vga_valid,
   output logic              vga_stall,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_ISSUE   = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

   localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT - 1);
   localparam logic [7:0] WAIT_START = (MAX_WAIT > 1) ? 8'd1 : 8'd0;

   // Handshake: cpu_req is held high until cpu_ack pulses for one cycle; the
   // request is not re-sampled in the ack cycle, so a still-high cpu_req on the
   // following cycle starts a new access with whatever we/address/wdata it shows.

   logic [1:0]        state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              op_we_q, op_we_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              vga_pipe_q, vga_pipe_d;
   logic              vga_valid_q, vga_valid_d;

   logic cpu_req_new;
   logic steal;
   logic vga_grant;
   logic cpu_grant;

   always_comb begin
      cpu_req_new = cpu_req && !cpu_ack_q;
      steal       = cpu_req_new && (state_q == S_WAIT) && (wait_cnt_q == WAIT_MAX);
      vga_grant   = !steal && vga_req;
      cpu_grant   = steal ||
                    (!vga_req && cpu_req_new && ((state_q == S_IDLE) || (state_q == S_WAIT)));
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      cpu_ack_d     = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      op_we_d       = op_we_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = 1'b0;
      vga_pipe_d    = vga_grant;
      vga_valid_d   = vga_pipe_q;

      // The CPU access is latched here so later bus changes cannot disturb it.
      if (cpu_grant) begin
         mem_address_d = cpu_address;
         mem_wdata_d   = cpu_wdata;
         mem_we_d      = cpu_we;
         op_we_d       = cpu_we;
      end else if (vga_grant) begin
         mem_address_d = vga_address;
      end

      case (state_q)
         S_IDLE: begin
            if (cpu_grant) begin
               state_d    = S_ISSUE;
               wait_cnt_d = 8'd0;
            end else if (cpu_req_new && vga_grant) begin
               state_d    = S_WAIT;
               wait_cnt_d = WAIT_START;
            end
         end
         S_WAIT: begin
            if (cpu_grant) begin
               state_d    = S_ISSUE;
               wait_cnt_d = 8'd0;
            end else if (!cpu_req) begin
               state_d    = S_IDLE;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q != WAIT_MAX) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_ISSUE: begin
            if (op_we_q) begin
               cpu_ack_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= 8'd0;
         cpu_ack_q     <= 1'b0;
         cpu_rdata_q   <= 8'd0;
         op_we_q       <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= 8'd0;
         mem_we_q      <= 1'b0;
         vga_pipe_q    <= 1'b0;
         vga_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_rdata_q   <= cpu_rdata_d;
         op_we_q       <= op_we_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         vga_pipe_q    <= vga_pipe_d;
         vga_valid_q   <= vga_valid_d;
      end
   end

   // Gating with RESET keeps a write already on the RAM pins from landing
   // in the cycle the transaction is aborted.
   assign mem_we      = mem_we_q && !RESET;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign vga_valid   = vga_valid_q;
   assign vga_data    = mem_rdata;
   assign vga_stall   = steal && vga_req;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model behind it.
module tb_vram_arbiter;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        vga_req;
   logic [16:0] vga_address;
   logic [7:0]  vga_data;
   logic        vga_valid;
   logic        vga_stall;
   logic        cpu_req;
   logic        cpu_we;
   logic [16:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic [16:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   logic [7:0] ram [0:131071];

   vram_arbiter #(.ADDR_W(17), .MAX_WAIT(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .vga_req(vga_req), .vga_address(vga_address), .vga_data(vga_data),
      .vga_valid(vga_valid), .vga_stall(vga_stall),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) begin
      if (mem_we) ram[mem_address] <= mem_wdata;
      mem_rdata <= ram[mem_address];
   end

   function automatic logic [7:0] pat(input logic [16:0] a);
      return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5C;
   endfunction

   task automatic idle(input int n);
      cpu_req = 1'b0;
      vga_req = 1'b0;
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   // Holds one CPU request until ack while VGA follows vmode (0 idle, 1 always, 2 alternating).
   // Returns at the start of the cycle after ack with cpu_req still high.
   task automatic cpu_txn(input logic we, input logic [16:0] addr, input logic [7:0] wd,
                          input int vmode, output int lat, output logic [7:0] rd,
                          output int n_stall, output int stall_cyc, output int n_we,
                          output int we_cyc, output logic [16:0] we_addr,
                          output logic [7:0] we_data, output int n_bad);
      logic        g  [0:63];
      logic [16:0] va [0:63];
      logic        vreq;
      logic        done;
      lat = -1; rd = 8'h00; n_stall = 0; stall_cyc = -1; n_we = 0; we_cyc = -1;
      we_addr = '0; we_data = 8'h00; n_bad = 0;
      for (int c = 0; c < 48; c++) begin
         vreq        = (vmode == 1) || ((vmode == 2) && (c % 2 == 0));
         vga_req     = vreq;
         vga_address = 17'h10000 + 17'(c);
         cpu_req     = 1'b1;
         cpu_we      = we;
         cpu_address = addr;
         cpu_wdata   = wd;
         @(negedge CLOCK);
         g[c]  = vreq && !vga_stall;
         va[c] = vga_address;
         if (vga_stall) begin
            n_stall++;
            if (stall_cyc < 0) stall_cyc = c;
         end
         if (mem_we) begin
            n_we++;
            we_cyc  = c;
            we_addr = mem_address;
            we_data = mem_wdata;
         end
         if (c >= 2) begin
            if (vga_valid !== g[c-2]) n_bad++;
            if (g[c-2] && (vga_data !== pat(va[c-2]))) n_bad++;
         end
         if ((c >= 1) && g[c-1] && (mem_address !== va[c-1])) n_bad++;
         done = (cpu_ack === 1'b1);
         if (done) begin
            lat = c;
            rd  = cpu_rdata;
         end
         @(posedge CLOCK);
         #1;
         if (done) break;
      end
      vga_req = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL reset_vga_valid got=%b exp=0", vga_valid); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_address !== 17'h0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
      checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      idle(2);
   endtask

   task automatic test_write_idle();
      int lat, ns, sc, nw, wc, nb;
      logic [7:0] rd, wdv;
      logic [16:0] wa;
      cpu_txn(1'b1, 17'h00123, 8'h5A, 0, lat, rd, ns, sc, nw, wc, wa, wdv, nb);
      cpu_req = 1'b0;
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_idle_latency got=%0d exp=2", lat); end
      checks++; if (wc !== 1) begin errors++; $display("FAIL write_idle_we_cycle got=%0d exp=1", wc); end
      checks++; if (nw !== 1) begin errors++; $display("FAIL write_idle_we_count got=%0d exp=1", nw); end
      checks++; if (wa !== 17'h00123) begin errors++; $display("FAIL write_idle_addr got=%h exp=00123", wa); end
      checks++; if (wdv !== 8'h5A) begin errors++; $display("FAIL write_idle_wdata got=%h exp=5a", wdv); end
      checks++; if (ram[17'h00123] !== 8'h5A) begin errors++; $display("FAIL write_idle_ram got=%h exp=5a", ram[17'h00123]); end
      idle(3);
   endtask

   task automatic test_read_idle();
      int lat, ns, sc, nw, wc, nb, spurious;
      logic [7:0] rd, wdv;
      logic [16:0] wa;
      cpu_txn(1'b0, 17'h01FA0, 8'h00, 0, lat, rd, ns, sc, nw, wc, wa, wdv, nb);
      cpu_req  = 1'b0;
      spurious = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK);
         if (cpu_ack !== 1'b0) spurious++;
         @(posedge CLOCK);
         #1;
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL read_idle_latency got=%0d exp=3", lat); end
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL read_idle_data got=%h exp=3c", rd); end
      checks++; if (nw !== 0) begin errors++; $display("FAIL read_idle_we_count got=%0d exp=0", nw); end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL read_idle_spurious_ack got=%0d exp=0", spurious); end
      idle(2);
   endtask

   task automatic test_steal();
      int lat, ns, sc, nw, wc, nb;
      logic [7:0] rd, wdv;
      logic [16:0] wa;
      cpu_txn(1'b1, 17'h00456, 8'hA7, 1, lat, rd, ns, sc, nw, wc, wa, wdv, nb);
      cpu_req = 1'b0;
      checks++; if (lat !== 17) begin errors++; $display("FAIL steal_latency got=%0d exp=17", lat); end
      checks++; if (ns !== 1) begin errors++; $display("FAIL steal_stall_count got=%0d exp=1", ns); end
      checks++; if (sc !== 15) begin errors++; $display("FAIL steal_stall_cycle got=%0d exp=15", sc); end
      checks++; if (wc !== 16) begin errors++; $display("FAIL steal_we_cycle got=%0d exp=16", wc); end
      checks++; if (wa !== 17'h00456) begin errors++; $display("FAIL steal_addr got=%h exp=00456", wa); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL steal_vga_slots bad=%0d exp=0", nb); end
      checks++; if (ram[17'h00456] !== 8'hA7) begin errors++; $display("FAIL steal_ram got=%h exp=a7", ram[17'h00456]); end
      idle(3);
   endtask

   task automatic test_alternating();
      int lat, ns, sc, nw, wc, nb;
      logic [7:0] rd, wdv;
      logic [16:0] wa;
      cpu_txn(1'b0, 17'h01FA0, 8'h00, 2, lat, rd, ns, sc, nw, wc, wa, wdv, nb);
      cpu_req = 1'b0;
      checks++; if (lat !== 4) begin errors++; $display("FAIL alt_latency got=%0d exp=4", lat); end
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL alt_data got=%h exp=3c", rd); end
      checks++; if (ns !== 0) begin errors++; $display("FAIL alt_stall_count got=%0d exp=0", ns); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL alt_vga_slots bad=%0d exp=0", nb); end
      idle(3);
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, ns, sc, nw, wc, nb;
      logic [7:0] rd1, rd2, wdv;
      logic [16:0] wa;
      cpu_txn(1'b0, 17'h00000, 8'h00, 0, lat1, rd1, ns, sc, nw, wc, wa, wdv, nb);
      cpu_txn(1'b0, 17'h00001, 8'h00, 0, lat2, rd2, ns, sc, nw, wc, wa, wdv, nb);
      cpu_req = 1'b0;
      checks++; if (lat1 !== 3) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=3", lat1); end
      checks++; if (rd1 !== 8'h11) begin errors++; $display("FAIL b2b_first_data got=%h exp=11", rd1); end
      checks++; if (lat2 !== 3) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=3", lat2); end
      checks++; if (rd2 !== 8'h22) begin errors++; $display("FAIL b2b_second_data got=%h exp=22", rd2); end
      idle(3);
   endtask

   task automatic test_reset_mid_write();
      cpu_req     = 1'b1;
      cpu_we      = 1'b1;
      cpu_address = 17'h00200;
      cpu_wdata   = 8'hEE;
      @(posedge CLOCK);
      #1;
      RESET = 1'b1;
      @(negedge CLOCK);
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL abort_in_issue state got=%0d exp=2", dbg_state); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we_gated got=%b exp=0", mem_we); end
      @(posedge CLOCK);
      #1;
      RESET   = 1'b0;
      cpu_req = 1'b0;
      @(negedge CLOCK);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we got=%b exp=0", mem_we); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_cpu_ack got=%b exp=0", cpu_ack); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
      checks++; if (mem_address !== 17'h0) begin errors++; $display("FAIL abort_mem_address got=%h exp=0", mem_address); end
      checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL abort_mem_wdata got=%h exp=00", mem_wdata); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL abort_cpu_rdata got=%h exp=00", cpu_rdata); end
      checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL abort_vga_valid got=%b exp=0", vga_valid); end
      @(posedge CLOCK);
      #1;
      @(negedge CLOCK);
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack got=%b exp=0", cpu_ack); end
      checks++; if (ram[17'h00200] !== 8'h77) begin errors++; $display("FAIL abort_ram got=%h exp=77", ram[17'h00200]); end
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      RESET       = 1'b1;
      vga_req     = 1'b0;
      vga_address = '0;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_address = '0;
      cpu_wdata   = 8'h00;
      for (int i = 0; i < 131072; i++) ram[i] <= pat(17'(i));
      ram[17'h01FA0] <= 8'h3C;
      ram[17'h00000] <= 8'h11;
      ram[17'h00001] <= 8'h22;
      ram[17'h00200] <= 8'h77;
      #1;
      test_reset();
      test_write_idle();
      test_read_idle();
      test_steal();
      test_alternating();
      test_back_to_back();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
